// File: rtl/tristate_bus_reader.sv
// Polls up to four tri-state sources one at a time (drive/sample/turn, 3 cycles each) into a 4x6 FIFO.
// A full FIFO holds the FSM in SAMPLE with the source still enabled until the consumer pops.

module tristate_bus_reader_fifo #(
  parameter int W = 6,
  parameter int D = 4
) (
  input  logic         clk,
  input  logic         clr,
  input  logic         in_vld,
  output logic         in_rdy,
  input  logic [W-1:0] in_dat,
  output logic         out_vld,
  input  logic         out_rdy,
  output logic [W-1:0] out_dat
);

  localparam int AW = $clog2(D);
  localparam int CW = $clog2(D + 1);

  logic [W-1:0]  mem [D];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic          full;
  logic          push;
  logic          pop;

  assign full    = (count == CW'(D));
  assign out_vld = (count != '0);
  assign pop     = out_vld && out_rdy;
  // A full FIFO can still take an entry when the head leaves on the same edge.
  assign in_rdy  = !full || out_rdy;
  assign push    = in_vld && in_rdy;
  assign out_dat = out_vld ? mem[rd_ptr] : '0;

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < D; i++) mem[i] <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= in_dat;
        wr_ptr      <= (wr_ptr == AW'(D - 1)) ? '0 : wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= (rd_ptr == AW'(D - 1)) ? '0 : rd_ptr + 1'b1;
      end
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

module tristate_bus_reader (
  input  logic       clk,
  input  logic       clr,
  input  logic       start,
  input  logic [3:0] src_mask,
  input  logic [3:0] bus,
  output logic [3:0] oe,
  output logic [5:0] out_data,
  output logic       out_valid,
  input  logic       out_ready,
  output logic       busy,
  output logic       done
);

  typedef enum logic [2:0] {IDLE, DRIVE, SAMPLE, TURN, FINISH} state_t;

  state_t     state, state_n;
  logic [3:0] scan_mask, scan_mask_n;
  logic [1:0] idx, idx_n;
  logic [3:0] oe_n;
  logic [3:0] remaining;
  logic       fifo_in_vld;
  logic       fifo_in_rdy;

  function automatic logic [1:0] lowest(input logic [3:0] m);
    lowest = 2'd0;
    for (int k = 3; k >= 0; k--) begin
      if (m[k]) lowest = 2'(k);
    end
  endfunction

  always_comb begin
    state_n     = state;
    scan_mask_n = scan_mask;
    idx_n       = idx;
    remaining   = scan_mask & ~(4'b0001 << idx);
    fifo_in_vld = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          scan_mask_n = src_mask;
          if (src_mask == 4'h0) begin
            state_n = FINISH;
          end else begin
            idx_n   = lowest(src_mask);
            state_n = DRIVE;
          end
        end
      end
      DRIVE: state_n = SAMPLE;
      SAMPLE: begin
        fifo_in_vld = 1'b1;
        if (fifo_in_rdy) state_n = TURN;
      end
      TURN: begin
        scan_mask_n = remaining;
        if (remaining != 4'h0) begin
          idx_n   = lowest(remaining);
          state_n = DRIVE;
        end else begin
          state_n = FINISH;
        end
      end
      FINISH:  state_n = IDLE;
      default: state_n = IDLE;
    endcase
    // oe is registered from the next state so the pins never see a glitch from start/bus/out_ready.
    oe_n = ((state_n == DRIVE) || (state_n == SAMPLE)) ? ~(4'b0001 << idx_n) : 4'hF;
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state     <= IDLE;
      scan_mask <= 4'h0;
      idx       <= 2'd0;
      oe        <= 4'hF;
    end else begin
      state     <= state_n;
      scan_mask <= scan_mask_n;
      idx       <= idx_n;
      oe        <= oe_n;
    end
  end

  assign busy = (state != IDLE);
  assign done = (state == FINISH);

  tristate_bus_reader_fifo #(.W(6), .D(4)) u_fifo (
    .clk     (clk),
    .clr     (clr),
    .in_vld  (fifo_in_vld),
    .in_rdy  (fifo_in_rdy),
    .in_dat  ({idx, bus}),
    .out_vld (out_valid),
    .out_rdy (out_ready),
    .out_dat (out_data)
  );

endmodule

// File: tb/tb_tristate_bus_reader.sv
// Directed bench: scan table plus back-pressure, abort and reset sequences.
module tb_tristate_bus_reader;

  logic       clk = 1'b0;
  logic       clr;
  logic       start;
  logic [3:0] src_mask;
  logic [3:0] bus;
  logic [3:0] oe;
  logic [5:0] out_data;
  logic       out_valid;
  logic       out_ready;
  logic       busy;
  logic       done;

  int total = 0;
  int bad   = 0;

  logic [3:0] srcv [4];
  logic [5:0] got [$];

  typedef struct {
    logic [3:0]  mask;
    int          done_cyc;
    logic [47:0] oe_seq;   // nibble k-1 is oe in cycle k after start, FINISH and later = F
    int          n;
    logic [23:0] dat;      // entry i at [6*i +: 6]
    int          poke;     // cycle in which a foreign start is injected, 0 = none
  } vec_t;

  vec_t tab [7];

  always #5 clk = ~clk;

  assign bus = !oe[0] ? srcv[0] : !oe[1] ? srcv[1] : !oe[2] ? srcv[2] : !oe[3] ? srcv[3] : 4'h0;

  tristate_bus_reader dut (
    .clk       (clk),
    .clr       (clr),
    .start     (start),
    .src_mask  (src_mask),
    .bus       (bus),
    .oe        (oe),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .busy      (busy),
    .done      (done)
  );

  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic run_scan(input int v);
    vec_t t;
    logic [3:0] exp_oe;
    t = tab[v];
    got.delete();
    out_ready = 1'b1;
    src_mask  = t.mask;
    start     = 1'b1;
    step();
    start    = 1'b0;
    src_mask = 4'h0;
    for (int k = 1; k <= t.done_cyc + 2; k++) begin
      exp_oe = (k < t.done_cyc) ? t.oe_seq[(k-1)*4 +: 4] : 4'hF;
      chk($sformatf("v%0d oe c%0d", v, k), 8'(oe), 8'(exp_oe));
      chk($sformatf("v%0d done c%0d", v, k), 8'(done), 8'(k == t.done_cyc));
      chk($sformatf("v%0d busy c%0d", v, k), 8'(busy), 8'(k <= t.done_cyc));
      if (out_valid && out_ready) got.push_back(out_data);
      if (k == t.poke) begin
        start    = 1'b1;
        src_mask = 4'b0101;
      end else begin
        start    = 1'b0;
        src_mask = 4'h0;
      end
      step();
    end
    start = 1'b0;
    chk($sformatf("v%0d count", v), 8'(got.size()), 8'(t.n));
    for (int i = 0; i < t.n && i < got.size(); i++)
      chk($sformatf("v%0d data%0d", v, i), 8'(got[i]), 8'(t.dat[6*i +: 6]));
  endtask

  task automatic wait_done();
    int n = 0;
    while (done !== 1'b1 && n < 50) begin
      step();
      n++;
    end
    chk("done_seen", 8'(done), 8'd1);
  endtask

  task automatic drain();
    got.delete();
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      if (out_valid) got.push_back(out_data);
      step();
    end
    out_ready = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    srcv[0] = 4'hA; srcv[1] = 4'h5; srcv[2] = 4'h3; srcv[3] = 4'hC;
    tab[0] = '{4'hF, 13, 48'hF77FBBFDDFEE, 4, {6'h3C, 6'h23, 6'h15, 6'h0A}, 0};
    tab[1] = '{4'hA,  7, 48'hFFFFFFF77FDD, 2, {6'h00, 6'h00, 6'h3C, 6'h15}, 0};
    tab[2] = '{4'h0,  1, 48'hFFFFFFFFFFFF, 0, 24'h0, 0};
    tab[3] = '{4'h1,  4, 48'hFFFFFFFFFFEE, 1, {6'h00, 6'h00, 6'h00, 6'h0A}, 0};
    tab[4] = '{4'h8,  4, 48'hFFFFFFFFFF77, 1, {6'h00, 6'h00, 6'h00, 6'h3C}, 0};
    tab[5] = '{4'hA,  7, 48'hFFFFFFF77FDD, 2, {6'h00, 6'h00, 6'h3C, 6'h15}, 2};
    tab[6] = '{4'hF, 13, 48'hF77FBBFDDFEE, 4, {6'h3C, 6'h23, 6'h15, 6'h0A}, 13};

    clr = 1'b1; start = 1'b0; src_mask = 4'h0; out_ready = 1'b0;
    #1;
    chk("rst oe", 8'(oe), 8'hF);
    chk("rst out_valid", 8'(out_valid), 8'd0);
    chk("rst out_data", 8'(out_data), 8'h00);
    chk("rst busy", 8'(busy), 8'd0);
    chk("rst done", 8'(done), 8'd0);
    @(negedge clk);
    clr = 1'b0;

    // Start in the same cycle reset releases: accepted on the first edge.
    for (int v = 0; v < 7; v++) run_scan(v);

    // Back-pressure: one leftover entry, then a full scan overflows into a stall.
    out_ready = 1'b0;
    src_mask = 4'h8; start = 1'b1;
    step();
    start = 1'b0;
    wait_done();
    step();
    chk("bp leftover vld", 8'(out_valid), 8'd1);
    chk("bp leftover dat", 8'(out_data), 8'h3C);
    src_mask = 4'hF; start = 1'b1;
    step();
    start = 1'b0;
    for (int k = 1; k < 14; k++) step();
    chk("bp stall oe", 8'(oe), 8'h7);
    chk("bp stall busy", 8'(busy), 8'd1);
    chk("bp stall done", 8'(done), 8'd0);
    chk("bp stall head", 8'(out_data), 8'h3C);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk("bp turn oe", 8'(oe), 8'hF);
    chk("bp new head", 8'(out_data), 8'h0A);
    chk("bp still vld", 8'(out_valid), 8'd1);
    step();
    chk("bp done", 8'(done), 8'd1);
    drain();
    chk("bp count", 8'(got.size()), 8'd4);
    if (got.size() == 4) begin
      chk("bp d0", 8'(got[0]), 8'h0A);
      chk("bp d1", 8'(got[1]), 8'h15);
      chk("bp d2", 8'(got[2]), 8'h23);
      chk("bp d3", 8'(got[3]), 8'h3C);
    end

    // Abort during SAMPLE of source 2 with two entries queued.
    out_ready = 1'b0;
    src_mask = 4'hF; start = 1'b1;
    step();
    start = 1'b0;
    for (int k = 1; k < 8; k++) step();
    chk("ab pre oe", 8'(oe), 8'hB);
    chk("ab pre vld", 8'(out_valid), 8'd1);
    #2 clr = 1'b1;
    #1;
    chk("ab oe", 8'(oe), 8'hF);
    chk("ab out_valid", 8'(out_valid), 8'd0);
    chk("ab out_data", 8'(out_data), 8'h00);
    chk("ab busy", 8'(busy), 8'd0);
    chk("ab done", 8'(done), 8'd0);
    @(negedge clk);
    chk("ab held done", 8'(done), 8'd0);
    clr = 1'b0;
    run_scan(0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
